// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;

  localparam int INSTR_W = 32;
  localparam int ADDR_W  = 32;
  localparam logic [ADDR_W-1:0] PC_INC = 32'd4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DROP
  } fetch_state_t;

  function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] a);
    return {a[ADDR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_prefetch_unit_if.sv
// Memory request, IF/ID delivery and branch-redirect signals of the fetch unit.
interface fetch_prefetch_unit_if;
  import fetch_pkg::*;

  logic               mem_req;
  logic [ADDR_W-1:0]  mem_addr;
  logic               mem_ack;
  logic [INSTR_W-1:0] mem_rdata;
  logic               out_valid;
  logic               out_ready;
  logic [INSTR_W-1:0] out_instr;
  logic [ADDR_W-1:0]  out_pc4;
  logic               redirect;
  logic [ADDR_W-1:0]  redirect_pc;

  modport master (
    output mem_req, mem_addr, out_valid, out_instr, out_pc4,
    input  mem_ack, mem_rdata, out_ready, redirect, redirect_pc
  );

  modport slave (
    input  mem_req, mem_addr, out_valid, out_instr, out_pc4,
    output mem_ack, mem_rdata, out_ready, redirect, redirect_pc
  );

endinterface

// File: rtl/fetch_fifo.sv
// Small instruction/PC+4 buffer; head comes straight from storage (no bypass).
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [INSTR_W-1:0]       push_instr,
  input  logic [ADDR_W-1:0]        push_pc4,
  output logic [$clog2(DEPTH):0]   count,
  output logic [INSTR_W-1:0]       head_instr,
  output logic [ADDR_W-1:0]        head_pc4
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0]   rd_ptr, wr_ptr;
  logic [INSTR_W-1:0] instr_mem [DEPTH];
  logic [ADDR_W-1:0]  pc4_mem   [DEPTH];
  logic               do_push, do_pop;

  // Flush wins over any same-cycle push or pop.
  assign do_push = push & ~flush;
  assign do_pop  = pop & ~flush & (count != '0);

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      instr_mem[wr_ptr] <= push_instr;
      pc4_mem[wr_ptr]   <= push_pc4;
    end
  end

  assign head_instr = instr_mem[rd_ptr];
  assign head_pc4   = pc4_mem[rd_ptr];

endmodule

// File: rtl/fetch_prefetch_unit.sv
// Fetch front end: owns the PC, keeps one memory request in flight, buffers words for IF/ID.
module fetch_prefetch_unit
  import fetch_pkg::*;
#(
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  fetch_prefetch_unit_if.master bus
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  fetch_state_t      state;
  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] pc_next;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_req;
  logic [CNT_W-1:0]  count;
  logic              out_valid;
  logic              push;
  logic              pop;
  logic              room_after_push;

  assign out_valid = (count != '0);
  assign pop       = out_valid & bus.out_ready;
  assign push      = (state == WAIT) & bus.mem_ack & ~bus.redirect;
  assign pc_next   = fetch_pc + PC_INC;
  // A pop in the same cycle frees the slot the push is about to take.
  assign room_after_push = (count < CNT_W'(DEPTH - 1)) | pop;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      mem_req  <= 1'b0;
      mem_addr <= RESET_PC;
    end else if (bus.redirect) begin
      fetch_pc <= word_align(bus.redirect_pc);
      if (state == IDLE || bus.mem_ack) begin
        state   <= IDLE;
        mem_req <= 1'b0;
      end else begin
        state <= DROP;
      end
    end else begin
      case (state)
        IDLE: begin
          if (count < CNT_W'(DEPTH)) begin
            mem_req  <= 1'b1;
            mem_addr <= fetch_pc;
            state    <= WAIT;
          end
        end
        WAIT: begin
          if (bus.mem_ack) begin
            fetch_pc <= pc_next;
            if (room_after_push) begin
              mem_addr <= pc_next;
            end else begin
              mem_req <= 1'b0;
              state   <= IDLE;
            end
          end
        end
        DROP: begin
          if (bus.mem_ack) begin
            mem_req <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .pop        (pop),
    .flush      (bus.redirect),
    .push_instr (bus.mem_rdata),
    .push_pc4   (pc_next),
    .count      (count),
    .head_instr (bus.out_instr),
    .head_pc4   (bus.out_pc4)
  );

  assign bus.mem_req   = mem_req;
  assign bus.mem_addr  = mem_addr;
  assign bus.out_valid = out_valid;

endmodule
